bf_weight_ctrl: RTL and testbench
=================================

# bf_weight_ctrl

Weight-update controller for the 8-channel beamformer. Host writes the 5-bit phase-shift weights (w_cos_1, w_sin_1, w_cos_2, w_sin_2 per channel) into a shadow bank over a valid/ready port. On request, all 32 weights are committed atomically into the active bank that drives the beamformer. The commit is aligned to the 4-phase LO sequence boundary, so no DSM channel ever mixes old and new weights within one LO period.

## Interface
- No parameters; fixed at 8 channels × 4 weights × 5 bits.
- clock  in  1  system clock, same domain as the beamformer datapath
- reset  in  1  synchronous, active-high
- lo_phase  in  2  current LO counter value from the datapath (0,1,2,3 repeating)
- wr_valid  in  1  host write request
- wr_ready  out  1  controller can accept a write
- wr_addr  in  5  [4:2] = channel 0–7; [1:0] = 0 cos_1, 1 sin_1, 2 cos_2, 3 sin_2
- wr_data  in  5  weight value, two's complement
- commit_req  in  1  single-cycle request to transfer shadow to active
- commit_done  out  1  one-cycle pulse; new active weights are visible this cycle
- pending  out  1  commit requested but not yet performed
- dirty  out  1  shadow written since last commit
- commit_cnt  out  8  number of commits performed, wraps 255→0
- w_cos_1, w_sin_1, w_cos_2, w_sin_2  out  5 × [7:0] each  active weights, unpacked arrays indexed by channel

## Operation
- State machine IDLE, PEND.
- IDLE:
  - wr_ready=1.
  - A write is accepted when wr_valid & wr_ready; shadow[wr_addr] ← wr_data at that edge, and dirty ← 1.
  - commit_req → PEND.
  - A write and commit_req in the same cycle: the write is accepted and is included in the commit.
- PEND:
  - wr_ready=0, pending=1.
  - commit_req is ignored; it is not queued.
  - On the edge that ends a PEND cycle with lo_phase==3:
    - all 32 active registers ← shadow;
    - dirty ← 0;
    - commit_cnt ← commit_cnt+1 (mod 256);
    - next state IDLE;
    - commit_done ← 1 for exactly the following cycle.
- A commit with dirty=0 still executes and increments commit_cnt.
- The active bank changes only on commit. The shadow bank changes only on accepted writes.
- Reset values: state IDLE; all shadow and active weights 0; dirty 0; pending 0; commit_done 0; commit_cnt 0; wr_ready 1 in the first cycle after reset.
- Reset during PEND: abort. No commit, no commit_done, both banks cleared.
- lo_phase is sampled as-is; the controller never drives or predicts it.

## Timing
- Write latency: shadow updated at the accepting edge; not visible on the outputs until a commit.
- Active outputs are registered directly; there is no combinational path from wr_* or commit_req to any w_* output.
- Commit latency:
  - commit_req sampled at phase p; PEND is entered at the next edge.
  - Copy occurs at the edge ending the first PEND cycle with lo_phase==3.
  - From the commit_req edge to new weights: 2 edges (p=2) up to 5 edges (p=3).
  - New weights are first used in a lo_phase==0 cycle.
- commit_done and the new w_* values appear in the same cycle. pending deasserts in that cycle.
- wr_ready is low from the cycle after commit_req through the copy edge. It is high again in the commit_done cycle.
- Max commit rate: one per 4 cycles.

## Test plan
- Reset, then write channel 3 cos_1 = 5'b01010.
  - Shadow updated and dirty=1; w_cos_1[3] stays 0.
  - Commit at phase 2: w_cos_1[3]=01010 and commit_done two edges after the request edge; cnt=1, dirty=0.
- commit_req at lo_phase 3: wr_ready low for 4 cycles; copy at the next phase-3 edge (5 edges later); commit_done coincides with lo_phase==0.
- Write all 32 addresses with value = addr[4:0]; commit.
  - Every output equals its address value, e.g. w_sin_2[7]=5'b11111.
  - Mapping check: w_sin_1[0]=1, w_cos_2[1]=6.
- Write asserted with wr_valid=1 during PEND: not accepted, shadow unchanged. Second commit_req during PEND: ignored, only one commit_done, cnt +1.
- Assert reset during PEND after a write: no commit_done; all outputs 0; cnt 0; wr_ready=1 the next cycle.
- 256 back-to-back commits: commit_cnt wraps to 0; each commit_done is spaced exactly 4 cycles apart once steady.

Source files
------------

// File: rtl/bf_weight_ctrl.sv
// bf_weight_ctrl: shadow/active weight banks for the 8-channel beamformer.
// The host fills the shadow bank one 5-bit weight at a time over a
// valid/ready port; a commit request then copies all 32 weights into the
// active bank at the end of an LO period (lo_phase==3), so that the
// datapath sees the new weights starting on a lo_phase==0 cycle and never
// mixes old and new values inside one LO sequence.

module bf_weight_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] lo_phase,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       commit_req,
  output logic       commit_done,
  output logic       pending,
  output logic       dirty,
  output logic [7:0] commit_cnt,
  output logic [4:0] w_cos_1 [8],
  output logic [4:0] w_sin_1 [8],
  output logic [4:0] w_cos_2 [8],
  output logic [4:0] w_sin_2 [8]
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Weight slot within a channel, taken from wr_addr[1:0].
  typedef enum logic [1:0] {
    SLOT_COS_1 = 2'd0,
    SLOT_SIN_1 = 2'd1,
    SLOT_COS_2 = 2'd2,
    SLOT_SIN_2 = 2'd3
  } slot_t;

  localparam logic [1:0] LAST_LO_PHASE = 2'd3;

  state_t     state;
  logic [4:0] shadow [8][4];

  logic       wr_fire;
  logic       commit_fire;
  logic [2:0] wr_chan;
  logic [1:0] wr_slot;

  assign wr_chan     = wr_addr[4:2];
  assign wr_slot     = wr_addr[1:0];
  // A write is only possible in IDLE, since wr_ready is low throughout PEND.
  assign wr_fire     = wr_valid && wr_ready;
  // The copy happens on the edge that closes an LO period while a commit waits.
  assign commit_fire = (state == PEND) && (lo_phase == LAST_LO_PHASE);

  // Control FSM, shadow bank and active bank; every output is a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wr_ready    <= 1'b1;
      pending     <= 1'b0;
      commit_done <= 1'b0;
      dirty       <= 1'b0;
      commit_cnt  <= 8'd0;
      // NOTE: both weight banks are cleared on reset on purpose; an aborted
      // commit must leave the beamformer with all-zero weights, and a fresh
      // commit after reset must not expose stale shadow contents.
      for (int ch = 0; ch < 8; ch++) begin
        for (int k = 0; k < 4; k++) begin
          shadow[ch][k] <= 5'd0;
        end
        w_cos_1[ch] <= 5'd0;
        w_sin_1[ch] <= 5'd0;
        w_cos_2[ch] <= 5'd0;
        w_sin_2[ch] <= 5'd0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so a write accepted on
      // the same edge as commit_req lands in the shadow before any later copy
      // reads it, and the copy always reads the shadow as it was before the edge.
      commit_done <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_fire) begin
            shadow[wr_chan][wr_slot] <= wr_data;
            dirty                    <= 1'b1;
          end
          if (commit_req) begin
            state    <= PEND;
            wr_ready <= 1'b0;
            pending  <= 1'b1;
          end
        end

        PEND: begin
          // Further commit_req pulses are dropped here; they are not queued.
          if (commit_fire) begin
            for (int ch = 0; ch < 8; ch++) begin
              w_cos_1[ch] <= shadow[ch][SLOT_COS_1];
              w_sin_1[ch] <= shadow[ch][SLOT_SIN_1];
              w_cos_2[ch] <= shadow[ch][SLOT_COS_2];
              w_sin_2[ch] <= shadow[ch][SLOT_SIN_2];
            end
            dirty       <= 1'b0;
            commit_cnt  <= commit_cnt + 8'd1;
            state       <= IDLE;
            wr_ready    <= 1'b1;
            pending     <= 1'b0;
            commit_done <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          wr_ready <= 1'b1;
          pending  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_weight_ctrl.sv
// Directed testbench for bf_weight_ctrl. A single thread drives every input
// one time unit after each rising edge (lo_phase included, advancing 0..3)
// and samples outputs at the same point, so stimulus and checks never race
// the clock edge.

module tb_bf_weight_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] lo_phase = 2'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [4:0] wr_addr = 5'd0;
  logic [4:0] wr_data = 5'd0;
  logic       commit_req = 1'b0;
  logic       commit_done;
  logic       pending;
  logic       dirty;
  logic [7:0] commit_cnt;
  logic [4:0] w_cos_1 [8];
  logic [4:0] w_sin_1 [8];
  logic [4:0] w_cos_2 [8];
  logic [4:0] w_sin_2 [8];

  int n_cmp = 0;
  int n_err = 0;

  bf_weight_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .lo_phase    (lo_phase),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit_req  (commit_req),
    .commit_done (commit_done),
    .pending     (pending),
    .dirty       (dirty),
    .commit_cnt  (commit_cnt),
    .w_cos_1     (w_cos_1),
    .w_sin_1     (w_sin_1),
    .w_cos_2     (w_cos_2),
    .w_sin_2     (w_sin_2)
  );

  always #5 clock = ~clock;

  // Advance one cycle: rising edge, settle, then step the LO phase for the new cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    lo_phase = lo_phase + 2'd1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    while (lo_phase != p) tick();
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [4:0] data);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  // Issue a commit_req with lo_phase==p and return how many edges, counting
  // the request edge, it took until commit_done is visible.
  task automatic do_commit(input logic [1:0] p, output int lat);
    wait_phase(p);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    lat = 1;
    while (commit_done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    n_cmp++; if (commit_done !== 1'b1) begin n_err++; $display("FAIL commit_timeout: commit_done=%b after %0d edges, required 1", commit_done, lat); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b want 0", pending); end
    n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL rst_commit_done: got %b want 0", commit_done); end
    n_cmp++; if (dirty !== 1'b0) begin n_err++; $display("FAIL rst_dirty: got %b want 0", dirty); end
    n_cmp++; if (commit_cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", commit_cnt); end
    for (int ch = 0; ch < 8; ch++) begin
      n_cmp++;
      if ({w_cos_1[ch], w_sin_1[ch], w_cos_2[ch], w_sin_2[ch]} !== 20'd0) begin
        n_err++; $display("FAIL rst_weights ch%0d: got %h %h %h %h want all 0", ch, w_cos_1[ch], w_sin_1[ch], w_cos_2[ch], w_sin_2[ch]);
      end
    end
    reset = 1'b0;
    tick();
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready_after: got %b want 1", wr_ready); end
  endtask

  task automatic test_write_commit_p2();
    int lat;
    do_write(5'b01100, 5'b01010);  // channel 3, cos_1
    n_cmp++; if (dirty !== 1'b1) begin n_err++; $display("FAIL wr_dirty: got %b want 1", dirty); end
    n_cmp++; if (w_cos_1[3] !== 5'd0) begin n_err++; $display("FAIL wr_no_leak: w_cos_1[3]=%b want 00000", w_cos_1[3]); end
    tick();
    n_cmp++; if (w_cos_1[3] !== 5'd0) begin n_err++; $display("FAIL wr_no_leak2: w_cos_1[3]=%b want 00000", w_cos_1[3]); end
    do_commit(2'd2, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL p2_latency: got %0d edges want 2", lat); end
    n_cmp++; if (w_cos_1[3] !== 5'b01010) begin n_err++; $display("FAIL p2_weight: w_cos_1[3]=%b want 01010", w_cos_1[3]); end
    n_cmp++; if (commit_cnt !== 8'd1) begin n_err++; $display("FAIL p2_cnt: got %0d want 1", commit_cnt); end
    n_cmp++; if (dirty !== 1'b0) begin n_err++; $display("FAIL p2_dirty: got %b want 0", dirty); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL p2_pending: got %b want 0", pending); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL p2_wr_ready: got %b want 1", wr_ready); end
    n_cmp++; if (lo_phase !== 2'd0) begin n_err++; $display("FAIL p2_phase: done in phase %0d want 0", lo_phase); end
    tick();
    n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL p2_done_width: got %b want 0", commit_done); end
  endtask

  task automatic test_commit_p3();
    wait_phase(2'd3);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (wr_ready !== 1'b0 || pending !== 1'b1 || commit_done !== 1'b0) begin
        n_err++; $display("FAIL p3_pend_cycle%0d: ready=%b pending=%b done=%b want 0 1 0", k, wr_ready, pending, commit_done);
      end
      tick();
    end
    n_cmp++; if (commit_done !== 1'b1) begin n_err++; $display("FAIL p3_done: got %b want 1", commit_done); end
    n_cmp++; if (lo_phase !== 2'd0) begin n_err++; $display("FAIL p3_phase: got %0d want 0", lo_phase); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL p3_wr_ready: got %b want 1", wr_ready); end
    n_cmp++; if (commit_cnt !== 8'd2) begin n_err++; $display("FAIL p3_cnt: got %0d want 2", commit_cnt); end
    n_cmp++; if (w_cos_1[3] !== 5'b01010) begin n_err++; $display("FAIL p3_clean_commit: w_cos_1[3]=%b want 01010", w_cos_1[3]); end
  endtask

  task automatic test_all_weights();
    int lat;
    logic [4:0] e;
    for (int a = 0; a < 32; a++) do_write(5'(a), 5'(a));
    do_commit(2'd1, lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL all_latency: got %0d edges want 3", lat); end
    for (int ch = 0; ch < 8; ch++) begin
      e = 5'(ch * 4);
      n_cmp++; if (w_cos_1[ch] !== e) begin n_err++; $display("FAIL all_cos1[%0d]: got %0d want %0d", ch, w_cos_1[ch], e); end
      e = 5'(ch * 4 + 1);
      n_cmp++; if (w_sin_1[ch] !== e) begin n_err++; $display("FAIL all_sin1[%0d]: got %0d want %0d", ch, w_sin_1[ch], e); end
      e = 5'(ch * 4 + 2);
      n_cmp++; if (w_cos_2[ch] !== e) begin n_err++; $display("FAIL all_cos2[%0d]: got %0d want %0d", ch, w_cos_2[ch], e); end
      e = 5'(ch * 4 + 3);
      n_cmp++; if (w_sin_2[ch] !== e) begin n_err++; $display("FAIL all_sin2[%0d]: got %0d want %0d", ch, w_sin_2[ch], e); end
    end
    n_cmp++; if (w_sin_2[7] !== 5'b11111) begin n_err++; $display("FAIL map_sin2_7: got %b want 11111", w_sin_2[7]); end
    n_cmp++; if (w_sin_1[0] !== 5'd1) begin n_err++; $display("FAIL map_sin1_0: got %0d want 1", w_sin_1[0]); end
    n_cmp++; if (w_cos_2[1] !== 5'd6) begin n_err++; $display("FAIL map_cos2_1: got %0d want 6", w_cos_2[1]); end
    n_cmp++; if (commit_cnt !== 8'd3) begin n_err++; $display("FAIL all_cnt: got %0d want 3", commit_cnt); end
  endtask

  task automatic test_pend_blocking();
    int extra_done;
    int lat;
    do_write(5'd0, 5'b00111);
    wait_phase(2'd0);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    n_cmp++; if (pending !== 1'b1 || wr_ready !== 1'b0) begin n_err++; $display("FAIL pend_flags: pending=%b ready=%b want 1 0", pending, wr_ready); end
    // Hold a write through all three PEND cycles and pulse a second request.
    wr_valid   = 1'b1;
    wr_addr    = 5'd0;
    wr_data    = 5'b10101;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    tick();
    wr_valid = 1'b0;
    n_cmp++; if (commit_done !== 1'b1) begin n_err++; $display("FAIL pend_done: got %b want 1", commit_done); end
    n_cmp++; if (w_cos_1[0] !== 5'b00111) begin n_err++; $display("FAIL pend_write_blocked: w_cos_1[0]=%b want 00111", w_cos_1[0]); end
    n_cmp++; if (commit_cnt !== 8'd4) begin n_err++; $display("FAIL pend_cnt: got %0d want 4", commit_cnt); end
    n_cmp++; if (dirty !== 1'b0) begin n_err++; $display("FAIL pend_dirty: got %b want 0", dirty); end
    extra_done = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (commit_done === 1'b1) extra_done++;
    end
    n_cmp++; if (extra_done !== 0) begin n_err++; $display("FAIL pend_req_ignored: %0d extra commit_done pulses, want 0", extra_done); end
    n_cmp++; if (commit_cnt !== 8'd4) begin n_err++; $display("FAIL pend_cnt_after: got %0d want 4", commit_cnt); end
    // A clean commit re-copies the untouched shadow and still counts.
    do_commit(2'd2, lat);
    n_cmp++; if (w_cos_1[0] !== 5'b00111) begin n_err++; $display("FAIL shadow_unchanged: w_cos_1[0]=%b want 00111", w_cos_1[0]); end
    n_cmp++; if (commit_cnt !== 8'd5) begin n_err++; $display("FAIL clean_cnt: got %0d want 5", commit_cnt); end
  endtask

  task automatic test_reset_in_pend();
    int lat;
    int seen_done;
    do_write(5'd31, 5'b00001);
    n_cmp++; if (dirty !== 1'b1) begin n_err++; $display("FAIL rp_dirty_before: got %b want 1", dirty); end
    wait_phase(2'd0);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL rp_pending: got %b want 1", pending); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (commit_done !== 1'b0 || pending !== 1'b0 || dirty !== 1'b0) begin
      n_err++; $display("FAIL rp_flags: done=%b pending=%b dirty=%b want 0 0 0", commit_done, pending, dirty);
    end
    n_cmp++; if (commit_cnt !== 8'd0) begin n_err++; $display("FAIL rp_cnt: got %0d want 0", commit_cnt); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rp_wr_ready: got %b want 1", wr_ready); end
    n_cmp++; if (w_cos_1[0] !== 5'd0 || w_sin_2[7] !== 5'd0 || w_cos_2[1] !== 5'd0) begin
      n_err++; $display("FAIL rp_active_cleared: %b %b %b want 0", w_cos_1[0], w_sin_2[7], w_cos_2[1]);
    end
    seen_done = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (commit_done === 1'b1) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_err++; $display("FAIL rp_no_done: %0d commit_done pulses want 0", seen_done); end
    do_commit(2'd3, lat);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL rp_p3_latency: got %0d edges want 5", lat); end
    n_cmp++; if (w_sin_2[7] !== 5'd0 || w_cos_1[0] !== 5'd0) begin
      n_err++; $display("FAIL rp_shadow_cleared: w_sin_2[7]=%b w_cos_1[0]=%b want 0", w_sin_2[7], w_cos_1[0]);
    end
    n_cmp++; if (commit_cnt !== 8'd1) begin n_err++; $display("FAIL rp_cnt_after: got %0d want 1", commit_cnt); end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int last_c;
    int extra_done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_done = 0;
    last_c = 0;
    commit_req = 1'b1;
    for (int c = 0; c < 1500 && n_done < 256; c++) begin
      tick();
      if (commit_done === 1'b1) begin
        n_done++;
        n_cmp++; if (commit_cnt !== 8'(n_done)) begin n_err++; $display("FAIL b2b_cnt #%0d: got %0d want %0d", n_done, commit_cnt, 8'(n_done)); end
        if (n_done > 1) begin
          n_cmp++; if (c - last_c !== 4) begin n_err++; $display("FAIL b2b_spacing #%0d: %0d cycles want 4", n_done, c - last_c); end
        end
        last_c = c;
        if (n_done == 256) commit_req = 1'b0;
      end
    end
    commit_req = 1'b0;
    n_cmp++; if (n_done !== 256) begin n_err++; $display("FAIL b2b_timeout: saw %0d commits want 256", n_done); end
    n_cmp++; if (commit_cnt !== 8'd0) begin n_err++; $display("FAIL b2b_wrap: got %0d want 0", commit_cnt); end
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (commit_done === 1'b1) extra_done++;
    end
    n_cmp++; if (extra_done !== 0) begin n_err++; $display("FAIL b2b_stop: %0d extra commits want 0", extra_done); end
  endtask

  initial begin
    test_reset();
    test_write_commit_p2();
    test_commit_p3();
    test_all_weights();
    test_pend_blocking();
    test_reset_in_pend();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
